// File: rtl/seq_mult_ctl_if.sv
// Start/busy/done handshake bundle for the sequential multiplier.
// master = requester (ALU), slave = multiplier.
interface seq_mult_ctl_if #(
   parameter int W = 32
);
   logic         start;
   logic         signed_mode;
   logic [W-1:0] multiplicand;
   logic [W-1:0] multiplier;
   logic         busy;
   logic         done;
   logic [W-1:0] product_hi;
   logic [W-1:0] product_lo;

   modport master (
      output start, signed_mode, multiplicand, multiplier,
      input  busy, done, product_hi, product_lo
   );

   modport slave (
      input  start, signed_mode, multiplicand, multiplier,
      output busy, done, product_hi, product_lo
   );
endinterface

// File: rtl/seq_mult_ctl.sv
// Sequential shift-add multiplier, W iterations plus one sign-fix cycle.
// Signed operands are multiplied as magnitudes and the sign is applied last.
module seq_mult_ctl #(
   parameter int W = 32
) (
   input  logic          clk,
   input  logic          rst,
   seq_mult_ctl_if.slave bus
);
   localparam int CW = $clog2(W) + 1;

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t          state;
   state_t          state_nx;
   logic [2*W:0]    acc;
   logic [W-1:0]    mcand;
   logic            neg;
   logic [CW-1:0]   cnt;
   logic            busy_q;
   logic            done_q;
   logic [W-1:0]    prod_hi;
   logic [W-1:0]    prod_lo;

   logic            accept;
   logic            last;
   logic [W-1:0]    abs_a;
   logic [W-1:0]    abs_b;
   logic            neg_in;
   logic [W:0]      sum;
   logic [W:0]      hi_nx;
   logic [2*W-1:0]  res;

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      last     = (cnt == CW'(W - 1));
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               accept   = 1'b1;
               state_nx = RUN;
            end
         end
         RUN:     if (last) state_nx = FIX;
         FIX:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // |x| of the most negative value wraps to 2^(W-1), still exact unsigned
   always_comb begin
      abs_a = bus.multiplicand;
      abs_b = bus.multiplier;
      if (bus.signed_mode && bus.multiplicand[W-1])
         abs_a = -bus.multiplicand;
      if (bus.signed_mode && bus.multiplier[W-1])
         abs_b = -bus.multiplier;
      neg_in = bus.signed_mode &
               (bus.multiplicand[W-1] ^ bus.multiplier[W-1]);
      sum   = {1'b0, acc[2*W-1:W]} + {1'b0, mcand};
      hi_nx = acc[0] ? sum : acc[2*W:W];
      res   = neg ? -acc[2*W-1:0] : acc[2*W-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         acc     <= '0;
         mcand   <= '0;
         neg     <= 1'b0;
         cnt     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         prod_hi <= '0;
         prod_lo <= '0;
      end else begin
         state  <= state_nx;
         done_q <= 1'b0;
         unique case (state)
            IDLE: begin
               if (accept) begin
                  mcand  <= abs_a;
                  acc    <= {(W + 1)'(0), abs_b};
                  neg    <= neg_in;
                  cnt    <= '0;
                  busy_q <= 1'b1;
               end
            end
            RUN: begin
               acc <= {hi_nx, acc[W-1:0]} >> 1;
               cnt <= cnt + CW'(1);
            end
            FIX: begin
               prod_hi <= res[2*W-1:W];
               prod_lo <= res[W-1:0];
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.product_hi = prod_hi;
   assign bus.product_lo = prod_lo;
endmodule

// File: tb/tb_seq_mult_ctl.sv
// Directed bench for seq_mult_ctl at W=32, exhaustive W=2,
// and a handful of hand-picked W=64 vectors checked against a reference.
module tb_seq_mult_ctl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   seq_mult_ctl_if #(.W(32)) b32 ();
   seq_mult_ctl_if #(.W(2))  b2 ();
   seq_mult_ctl_if #(.W(64)) b64 ();

   seq_mult_ctl #(.W(32)) u_dut32 (.clk(clk), .rst(rst), .bus(b32));
   seq_mult_ctl #(.W(2))  u_dut2  (.clk(clk), .rst(rst), .bus(b2));
   seq_mult_ctl #(.W(64)) u_dut64 (.clk(clk), .rst(rst), .bus(b64));

   task automatic chk(input string tag, input logic [127:0] got,
                      input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait32(output int n);
      n = -1;
      for (int i = 1; i <= 80; i++) begin
         @(posedge clk); #1;
         if (b32.done) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic op32(input string tag, input logic [31:0] a,
                       input logic [31:0] b, input logic sm,
                       input logic [63:0] exp);
      int n;
      b32.multiplicand = a;
      b32.multiplier   = b;
      b32.signed_mode  = sm;
      b32.start        = 1'b1;
      @(posedge clk); #1;
      b32.start = 1'b0;
      chk({tag, "_busy"}, 128'(b32.busy), 128'(1));
      wait32(n);
      chk({tag, "_lat"}, 128'(n), 128'(33));
      chk({tag, "_prod"}, 128'({b32.product_hi, b32.product_lo}),
          128'(exp));
   endtask

   task automatic op2(input logic [1:0] a, input logic [1:0] b,
                      input logic sm);
      int n;
      logic [3:0] e;
      if (sm)
         e = 4'($signed({{2{a[1]}}, a}) * $signed({{2{b[1]}}, b}));
      else
         e = 4'({2'b00, a} * {2'b00, b});
      b2.multiplicand = a;
      b2.multiplier   = b;
      b2.signed_mode  = sm;
      b2.start        = 1'b1;
      @(posedge clk); #1;
      b2.start = 1'b0;
      n = -1;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk); #1;
         if (b2.done) begin
            n = i;
            break;
         end
      end
      chk($sformatf("w2_%0d_%0d_%0d_lat", a, b, sm), 128'(n), 128'(3));
      chk($sformatf("w2_%0d_%0d_%0d", a, b, sm),
          128'({b2.product_hi, b2.product_lo}), 128'(e));
   endtask

   task automatic op64(input logic [63:0] a, input logic [63:0] b,
                       input logic sm);
      int n;
      logic [127:0] e;
      if (sm)
         e = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
      else
         e = {64'd0, a} * {64'd0, b};
      b64.multiplicand = a;
      b64.multiplier   = b;
      b64.signed_mode  = sm;
      b64.start        = 1'b1;
      @(posedge clk); #1;
      b64.start = 1'b0;
      n = -1;
      for (int i = 1; i <= 80; i++) begin
         @(posedge clk); #1;
         if (b64.done) begin
            n = i;
            break;
         end
      end
      chk($sformatf("w64_%0h_%0h_%0d_lat", a, b, sm), 128'(n), 128'(65));
      chk($sformatf("w64_%0h_%0h_%0d", a, b, sm),
          {b64.product_hi, b64.product_lo}, e);
   endtask

   initial begin
      int n, t1, t2, ndone;
      b32.start = 0; b32.signed_mode = 0;
      b32.multiplicand = 0; b32.multiplier = 0;
      b2.start = 0; b2.signed_mode = 0;
      b2.multiplicand = 0; b2.multiplier = 0;
      b64.start = 0; b64.signed_mode = 0;
      b64.multiplicand = 0; b64.multiplier = 0;

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_busy", 128'(b32.busy), 128'(0));
      chk("rst_done", 128'(b32.done), 128'(0));
      chk("rst_prod", 128'({b32.product_hi, b32.product_lo}), 128'(0));

      op32("u_ff", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0,
           64'hFFFFFFFE_00000001);
      chk("u_ff_busy_end", 128'(b32.busy), 128'(0));
      op32("s_m3x5", 32'hFFFFFFFD, 32'h5, 1'b1, 64'hFFFFFFFF_FFFFFFF1);
      op32("u_m3x5", 32'hFFFFFFFD, 32'h5, 1'b0, 64'h00000004_FFFFFFF1);
      op32("s_minxmin", 32'h80000000, 32'h80000000, 1'b1,
           64'h40000000_00000000);
      op32("s_minx1", 32'h80000000, 32'h1, 1'b1, 64'hFFFFFFFF_80000000);
      op32("s_0xm1", 32'h0, 32'hFFFFFFFF, 1'b1, 64'h0);

      // second start while busy must be ignored
      b32.multiplicand = 7; b32.multiplier = 6;
      b32.signed_mode = 0; b32.start = 1;
      @(posedge clk); #1;
      b32.start = 0;
      repeat (4) begin @(posedge clk); #1; end
      b32.multiplicand = 9; b32.multiplier = 9; b32.start = 1;
      @(posedge clk); #1;
      b32.start = 0;
      wait32(n);
      chk("busy_ign_lat", 128'(n + 5), 128'(33));
      chk("busy_ign_prod", 128'({b32.product_hi, b32.product_lo}),
          128'(42));

      // held-high start: back-to-back operations
      b32.multiplicand = 2; b32.multiplier = 3; b32.start = 1;
      @(posedge clk); #1;
      b32.multiplicand = 4; b32.multiplier = 5;
      wait32(n);
      t1 = cyc;
      chk("b2b_first", 128'({b32.product_hi, b32.product_lo}), 128'(6));
      @(posedge clk); #1;
      b32.start = 0;
      chk("b2b_busy", 128'(b32.busy), 128'(1));
      wait32(n);
      t2 = cyc;
      chk("b2b_second", 128'({b32.product_hi, b32.product_lo}), 128'(20));
      chk("b2b_gap", 128'(t2 - t1), 128'(34));

      // asynchronous reset in the middle of RUN
      b32.multiplicand = 32'h1234; b32.multiplier = 32'h5678;
      b32.start = 1;
      @(posedge clk); #1;
      b32.start = 0;
      repeat (10) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("arst_busy", 128'(b32.busy), 128'(0));
      chk("arst_done", 128'(b32.done), 128'(0));
      chk("arst_prod", 128'({b32.product_hi, b32.product_lo}), 128'(0));
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (b32.done) ndone++;
      end
      chk("arst_no_done", 128'(ndone), 128'(0));
      op32("s_x0", 32'h12345678, 32'h0, 1'b1, 64'h0);

      for (int sm = 0; sm < 2; sm++)
         for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
               op2(2'(a), 2'(b), 1'(sm));

      op64(64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
      op64(64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b1);
      op64(64'h8000000000000000, 64'h8000000000000000, 1'b1);
      op64(64'h8000000000000000, 64'h7FFFFFFFFFFFFFFF, 1'b1);
      op64(64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 1'b0);
      op64(64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 1'b1);
      op64(64'hDEADBEEFCAFEF00D, 64'h0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule
